// File: rtl/dmem_dump_responder_pkg.sv
// Shared sizes, word type and dump FSM encoding for the data-memory dump responder.
package dmem_dump_responder_pkg;

  localparam int DMEM_DEPTH      = 256;
  localparam int DMEM_DUMP_WORDS = 128;
  localparam int WORD_W          = 64;

  typedef logic [0:WORD_W-1] word_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } dump_state_e;

endpackage

// File: rtl/dmem_dump_responder_array.sv
// Word-wide storage with one write port and one registered read port.
module dmem_array
  import dmem_dump_responder_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = $clog2(DMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  word_t         wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output word_t         rd_data
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dmem_dump_responder.sv
// Processor-priority data memory that can stream its first DUMP_WORDS words to a ready/valid consumer.
module dmem_dump_responder
  import dmem_dump_responder_pkg::*;
#(
  parameter int DEPTH      = DMEM_DEPTH,
  parameter int DUMP_WORDS = DMEM_DUMP_WORDS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       memEn,
  input  logic       memWrEn,
  input  logic [0:7] memAddr,
  input  word_t      dataIn,
  output word_t      dataOut,
  input  logic       dump_start,
  output logic       dump_valid,
  input  logic       dump_ready,
  output logic [7:0] dump_addr,
  output word_t      dump_data,
  output logic       dump_busy,
  output logic       dump_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DUMP_WORDS - 1);

  if (DUMP_WORDS > DEPTH || DUMP_WORDS < 1) begin : g_bad_cfg
    $error("dmem_dump_responder: DUMP_WORDS must be in 1..DEPTH");
  end

  dump_state_e   state;
  logic [AW-1:0] ptr;
  logic [7:0]    proc_addr;
  logic          proc_rd;
  logic          fetch_go;
  logic          arr_rd_en;
  logic [AW-1:0] arr_rd_addr;
  word_t         arr_rd_data;
  logic          proc_rd_vld_p1;
  logic          fetch_vld_p1;
  word_t         data_out_hold_p1;
  word_t         dump_hold_p1;

  assign proc_addr   = memAddr;
  assign proc_rd     = memEn && !memWrEn;
  // The processor owns the array whenever memEn is high; the dump only reads in idle cycles.
  assign fetch_go    = (state == ST_FETCH) && !memEn;
  assign arr_rd_en   = proc_rd || fetch_go;
  assign arr_rd_addr = memEn ? proc_addr[AW-1:0] : ptr;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .wr_en   (memEn && memWrEn),
    .wr_addr (proc_addr[AW-1:0]),
    .wr_data (dataIn),
    .rd_en   (arr_rd_en),
    .rd_addr (arr_rd_addr),
    .rd_data (arr_rd_data)
  );

  // Stage p1: the shared read register belongs to whichever client read last cycle;
  // each output otherwise keeps its own held copy.
  assign dataOut   = proc_rd_vld_p1 ? arr_rd_data : data_out_hold_p1;
  assign dump_data = fetch_vld_p1   ? arr_rd_data : dump_hold_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      proc_rd_vld_p1   <= 1'b0;
      fetch_vld_p1     <= 1'b0;
      data_out_hold_p1 <= '0;
      dump_hold_p1     <= '0;
    end else begin
      proc_rd_vld_p1   <= proc_rd;
      fetch_vld_p1     <= fetch_go;
      data_out_hold_p1 <= dataOut;
      dump_hold_p1     <= dump_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      dump_addr  <= '0;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (dump_start) begin
            state     <= ST_FETCH;
            ptr       <= '0;
            dump_busy <= 1'b1;
            dump_done <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (!memEn) begin
            state      <= ST_PRESENT;
            dump_addr  <= 8'(ptr);
            dump_valid <= 1'b1;
          end
        end
        ST_PRESENT: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (ptr == LAST_PTR) begin
              state     <= ST_DONE;
              dump_busy <= 1'b0;
              dump_done <= 1'b1;
            end else begin
              state <= ST_FETCH;
              ptr   <= ptr + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dump_responder.sv
// Directed bench for dmem_dump_responder: processor port vectors plus dump, stall, hold and abort sequences.
module tb_dmem_dump_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        memEn;
  logic        memWrEn;
  logic [7:0]  memAddr;
  logic [63:0] dataIn;
  logic [63:0] dataOut;
  logic        dump_start;
  logic        dump_valid;
  logic        dump_ready;
  logic [7:0]  dump_addr;
  logic [63:0] dump_data;
  logic        dump_busy;
  logic        dump_done;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [63:0] model [256];
  logic [63:0] exp_dout;

  always #5 clk = ~clk;

  dmem_dump_responder dut (
    .clk        (clk),
    .reset      (reset),
    .memEn      (memEn),
    .memWrEn    (memWrEn),
    .memAddr    (memAddr),
    .dataIn     (dataIn),
    .dataOut    (dataOut),
    .dump_start (dump_start),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  typedef struct {
    logic        en;
    logic        wr;
    logic [7:0]  addr;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic mem_write(input logic [7:0] a, input logic [63:0] d);
    memEn = 1'b1; memWrEn = 1'b1; memAddr = a; dataIn = d;
    tick;
    model[a] = d;
    memEn = 1'b0; memWrEn = 1'b0;
  endtask

  task automatic mem_read(input logic [7:0] a);
    memEn = 1'b1; memWrEn = 1'b0; memAddr = a;
    tick;
    exp_dout = model[a];
    check("proc_read", dataOut, exp_dout);
    memEn = 1'b0;
  endtask

  task automatic run_dump(input int stall_c, input int hold_idx, input int abort_idx,
                          output int words, output int cycles);
    int          idx;
    logic [63:0] cap;
    logic        rd_pend;
    logic [7:0]  rd_a;
    logic        aborted;
    idx = 0; cycles = 0; aborted = 1'b0; rd_a = 8'd0;
    dump_ready = 1'b1; dump_start = 1'b1;
    tick;
    dump_start = 1'b0;
    check("start_busy", 64'(dump_busy), 64'd1);
    check("start_done", 64'(dump_done), 64'd0);
    while (!dump_done && cycles < 600 && !aborted) begin
      memEn = 1'b0; memWrEn = 1'b0; rd_pend = 1'b0;
      if (stall_c >= 0 && cycles >= stall_c && cycles < stall_c + 10) begin
        memEn = 1'b1; memAddr = 8'(100 + cycles - stall_c);
        rd_pend = 1'b1; rd_a = memAddr;
      end
      if (dump_valid) begin
        cap = model[idx];
        check("dump_addr", 64'(dump_addr), 64'(idx));
        check("dump_data", dump_data, cap);
        if (idx == abort_idx) begin
          #1 reset = 1'b0;
          #1;
          check("abort_dataOut", dataOut, 64'd0);
          check("abort_valid", 64'(dump_valid), 64'd0);
          check("abort_addr", 64'(dump_addr), 64'd0);
          check("abort_data", dump_data, 64'd0);
          check("abort_busy", 64'(dump_busy), 64'd0);
          check("abort_done", 64'(dump_done), 64'd0);
          tick;
          reset = 1'b1;
          for (int k = 0; k < 3; k++) begin
            tick;
            check("post_abort_valid", 64'(dump_valid), 64'd0);
            check("post_abort_busy", 64'(dump_busy), 64'd0);
          end
          exp_dout = 64'd0;
          aborted = 1'b1;
        end else begin
          if (idx == hold_idx) begin
            dump_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
              memEn = 1'b0; memWrEn = 1'b0; dump_start = (k == 2);
              if (k == 1) begin
                memEn = 1'b1; memWrEn = 1'b1; memAddr = 8'(idx); dataIn = 64'h1111_2222_3333_4444;
              end
              if (k == 3) begin
                memEn = 1'b1; memWrEn = 1'b1; memAddr = 8'd60; dataIn = 64'hCAFE_F00D_0000_003C;
              end
              tick;
              if (memEn && memWrEn) model[memAddr] = dataIn;
              check("hold_valid", 64'(dump_valid), 64'd1);
              check("hold_addr", 64'(dump_addr), 64'(idx));
              check("hold_data", dump_data, cap);
            end
            memEn = 1'b0; memWrEn = 1'b0; dump_start = 1'b0; dump_ready = 1'b1;
          end
          idx++;
        end
      end
      if (!aborted) begin
        tick;
        cycles++;
        if (rd_pend) begin
          exp_dout = model[rd_a];
          check("stall_read", dataOut, exp_dout);
        end
      end
    end
    memEn = 1'b0;
    if (!aborted) begin
      check("dump_finished", 64'(dump_done), 64'd1);
      check("end_busy", 64'(dump_busy), 64'd0);
      check("end_valid", 64'(dump_valid), 64'd0);
      check("dataOut_held", dataOut, exp_dout);
    end
    words = idx;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int words;
    int cycles;
    vecs[0]  = '{1'b1, 1'b1, 8'd5,  64'h0123456789ABCDEF, 64'h0};
    vecs[1]  = '{1'b1, 1'b0, 8'd5,  64'h0,                64'h0123456789ABCDEF};
    vecs[2]  = '{1'b0, 1'b0, 8'd0,  64'h0,                64'h0123456789ABCDEF};
    vecs[3]  = '{1'b1, 1'b1, 8'd9,  64'hDEADBEEF00000001, 64'h0123456789ABCDEF};
    vecs[4]  = '{1'b1, 1'b0, 8'd9,  64'h0,                64'hDEADBEEF00000001};
    vecs[5]  = '{1'b1, 1'b0, 8'd7,  64'h0,                64'h7};
    vecs[6]  = '{1'b1, 1'b1, 8'd7,  64'hFFFFFFFFFFFFFFFF, 64'h7};
    vecs[7]  = '{1'b1, 1'b0, 8'd7,  64'h0,                64'hFFFFFFFFFFFFFFFF};
    vecs[8]  = '{1'b0, 1'b1, 8'd20, 64'hAAAAAAAAAAAAAAAA, 64'hFFFFFFFFFFFFFFFF};
    vecs[9]  = '{1'b1, 1'b0, 8'd20, 64'h0,                64'h14};
    vecs[10] = '{1'b1, 1'b1, 8'd5,  64'h5,                64'h14};
    vecs[11] = '{1'b1, 1'b1, 8'd9,  64'h9,                64'h14};
    vecs[12] = '{1'b1, 1'b1, 8'd7,  64'h7,                64'h14};
    vecs[13] = '{1'b1, 1'b0, 8'd9,  64'h0,                64'h9};

    reset = 1'b0; memEn = 1'b0; memWrEn = 1'b0; memAddr = 8'd0; dataIn = 64'd0;
    dump_start = 1'b0; dump_ready = 1'b0; exp_dout = 64'd0;
    tick;
    tick;
    check("rst_dataOut", dataOut, 64'd0);
    check("rst_valid", 64'(dump_valid), 64'd0);
    check("rst_addr", 64'(dump_addr), 64'd0);
    check("rst_data", dump_data, 64'd0);
    check("rst_busy", 64'(dump_busy), 64'd0);
    check("rst_done", 64'(dump_done), 64'd0);
    reset = 1'b1;
    tick;

    for (int i = 0; i < 256; i++) mem_write(8'(i), 64'(i));
    check("preload_hold", dataOut, 64'd0);

    for (int v = 0; v < 14; v++) begin
      memEn = vecs[v].en; memWrEn = vecs[v].wr; memAddr = vecs[v].addr; dataIn = vecs[v].din;
      tick;
      if (vecs[v].en && vecs[v].wr) model[vecs[v].addr] = vecs[v].din;
      if (vecs[v].en && !vecs[v].wr) exp_dout = model[vecs[v].addr];
      check($sformatf("vec%0d_dataOut", v), dataOut, vecs[v].exp);
    end
    memEn = 1'b0; memWrEn = 1'b0;

    run_dump(-1, -1, -1, words, cycles);
    check("plain_words", 64'(words), 64'd128);
    check("plain_cycles", 64'(cycles), 64'd256);

    run_dump(50, -1, -1, words, cycles);
    check("stall_words", 64'(words), 64'd128);
    check("stall_cycles", 64'(cycles), 64'd266);

    run_dump(-1, 10, -1, words, cycles);
    check("hold_words", 64'(words), 64'd128);

    mem_read(8'd5);
    run_dump(-1, -1, 40, words, cycles);
    check("abort_words", 64'(words), 64'd40);

    run_dump(-1, -1, -1, words, cycles);
    check("restart_words", 64'(words), 64'd128);
    check("restart_cycles", 64'(cycles), 64'd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
